// File: rtl/warp_dispatcher_pkg.sv
// Shared types and defaults for the warp dispatcher: FIFO entry, dispatched-warp
// record and default sizing. ID and thread-count widths are fixed here.
package warp_dispatcher_pkg;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_DEPTH     = 32;
  localparam int DEF_NUM_WARPS = 16;
  localparam int ID_W          = $clog2(DEF_NUM_WARPS);
  localparam int THREAD_W      = 4;

  typedef struct packed {
    logic [31:0]         start_pc;
    logic [THREAD_W-1:0] thread_count;
  } warp_req_t;

  typedef struct packed {
    logic [ID_W-1:0]     warp_id;
    logic [31:0]         start_pc;
    logic [THREAD_W-1:0] thread_count;
  } kernel_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/warp_dispatcher_if.sv
// Request, dispatch and completion handshakes between the dispatcher (slave)
// and its surrounding logic (master).
interface warp_dispatcher_if import warp_dispatcher_pkg::*; #(
  parameter int NUM_CH = DEF_NUM_CH
);
  logic [NUM_CH-1:0]                req_valid;
  logic [NUM_CH-1:0]                req_ready;
  logic [NUM_CH-1:0][THREAD_W-1:0]  req_threads;
  logic [NUM_CH-1:0][31:0]          req_pc;
  logic                             kernel_valid;
  logic                             kernel_ready;
  kernel_t                          kernel_out;
  logic                             done_valid;
  logic [ID_W-1:0]                  done_id;

  modport master (
    output req_valid, req_threads, req_pc, kernel_ready, done_valid, done_id,
    input  req_ready, kernel_valid, kernel_out
  );

  modport slave (
    input  req_valid, req_threads, req_pc, kernel_ready, done_valid, done_id,
    output req_ready, kernel_valid, kernel_out
  );
endinterface

// File: rtl/warp_id_pool.sv
// Warp ID free pool: busy bitmap, lowest-free allocation, release with
// sticky bad-release flag and an exact registered free count.
module warp_id_pool import warp_dispatcher_pkg::*; #(
  parameter int NUM_WARPS = DEF_NUM_WARPS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc,
  output logic [ID_W-1:0]              alloc_id,
  output logic                         any_free,
  input  logic                         rel_valid,
  input  logic [ID_W-1:0]              rel_id,
  output logic [$clog2(NUM_WARPS):0]   ids_free,
  output logic                         err_bad_release
);
  localparam int CW = $clog2(NUM_WARPS) + 1;

  logic [NUM_WARPS-1:0] busy, busy_nxt;
  logic                 rel_ok, rel_bad;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    alloc_id = '0;
    any_free = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (!any_free && !busy[i]) begin
        any_free = 1'b1;
        alloc_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    rel_ok  = 1'b0;
    rel_bad = 1'b0;
    if (rel_valid) begin
      if (int'(rel_id) < NUM_WARPS && busy[rel_id]) rel_ok  = 1'b1;
      else                                          rel_bad = 1'b1;
    end
  end

  // Allocation picks from the pre-release bitmap, so alloc and release never hit the same bit.
  always_comb begin
    busy_nxt = busy;
    if (alloc)  busy_nxt[alloc_id] = 1'b1;
    if (rel_ok) busy_nxt[rel_id]   = 1'b0;
  end

  // NOTE: clocked state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy            <= '0;
      ids_free        <= CW'(NUM_WARPS);
      err_bad_release <= 1'b0;
    end else begin
      busy            <= busy_nxt;
      ids_free        <= ids_free - CW'(alloc) + CW'(rel_ok);
      err_bad_release <= err_bad_release | rel_bad;
    end
  end

endmodule

// File: rtl/warp_dispatcher.sv
// Round-robin multi-channel warp dispatcher: pending FIFO, ID pool, registered
// issue stage. Define WARP_DISPATCH_STATS_EN to build the statistics counters.
module warp_dispatcher import warp_dispatcher_pkg::*; #(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_WARPS = DEF_NUM_WARPS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        launch_en,
  warp_dispatcher_if.slave            bus,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic [$clog2(NUM_WARPS):0]  ids_free,
  output logic                        err_bad_release,
  output logic [31:0]                 stat_dispatched,
  output logic [31:0]                 stat_id_stall
);
  localparam int AW   = $clog2(DEPTH);
  localparam int FW   = AW + 1;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]   rr_ptr, grant_idx;
  logic [NUM_CH-1:0] grant;
  logic              grant_any, accept, push, pop, full, empty;
  logic              any_free;
  logic [ID_W-1:0]   alloc_id;
  logic [AW:0]       wr_ptr, rd_ptr;
  warp_req_t         mem [DEPTH];
  warp_req_t         wdata, head;
  int                idx;

  // First valid channel at or after the round-robin pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = CH_W'(idx);
      end
    end
  end

  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.req_ready = full ? '0 : grant;
  assign accept        = grant_any && !full;
  assign wdata         = '{start_pc: bus.req_pc[grant_idx], thread_count: bus.req_threads[grant_idx]};
  assign push          = accept && (wdata.thread_count != '0);
  assign head          = mem[rd_ptr[AW-1:0]];
  assign pop           = !empty && launch_en && any_free && (!bus.kernel_valid || bus.kernel_ready);

  // NOTE: payload storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (accept) rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
      if (push)   wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)    rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FW'(1);
        2'b01:   fifo_count <= fifo_count - FW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.kernel_valid <= 1'b0;
      bus.kernel_out   <= '0;
    end else if (pop) begin
      bus.kernel_valid <= 1'b1;
      bus.kernel_out   <= '{warp_id: alloc_id, start_pc: head.start_pc,
                            thread_count: head.thread_count};
    end else if (bus.kernel_ready) begin
      bus.kernel_valid <= 1'b0;
    end
  end

  warp_id_pool #(.NUM_WARPS(NUM_WARPS)) u_pool (
    .clk             (clk),
    .rst             (rst),
    .alloc           (pop),
    .alloc_id        (alloc_id),
    .any_free        (any_free),
    .rel_valid       (bus.done_valid),
    .rel_id          (bus.done_id),
    .ids_free        (ids_free),
    .err_bad_release (err_bad_release)
  );

`ifdef WARP_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_dispatched <= '0;
      stat_id_stall   <= '0;
    end else begin
      if (bus.kernel_valid && bus.kernel_ready) stat_dispatched <= sat_inc(stat_dispatched);
      if (!empty && launch_en && !any_free)     stat_id_stall   <= sat_inc(stat_id_stall);
    end
  end
`else
  assign stat_dispatched = '0;
  assign stat_id_stall   = '0;
`endif

endmodule

// File: tb/tb_warp_dispatcher.sv
// Directed bench for warp_dispatcher: reset, arbitration, FIFO fill, ID
// exhaustion/release, issue-stage backpressure, bad release, zero-thread requests.
module tb_warp_dispatcher;
  import warp_dispatcher_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        launch_en = 1'b0;
  logic [5:0]  fifo_count;
  logic [4:0]  ids_free;
  logic        err_bad_release;
  logic [31:0] stat_dispatched, stat_id_stall;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  warp_dispatcher_if #(.NUM_CH(4)) bus ();

  warp_dispatcher #(.NUM_CH(4), .DEPTH(32), .NUM_WARPS(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .launch_en       (launch_en),
    .bus             (bus),
    .fifo_count      (fifo_count),
    .ids_free        (ids_free),
    .err_bad_release (err_bad_release),
    .stat_dispatched (stat_dispatched),
    .stat_id_stall   (stat_id_stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected record for FIFO entry e (channel e%4 pattern) carrying warp id.
  function automatic kernel_t exp_k(input int id, input int e);
    int ch;
    ch = e % 4;
    return '{warp_id: ID_W'(id), start_pc: 32'h1000 + 32'(ch) * 32'h10,
             thread_count: THREAD_W'(ch + 1)};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    kernel_t k1;
    bus.req_valid    = '0;
    bus.req_threads  = '0;
    bus.req_pc       = '0;
    bus.kernel_ready = 1'b0;
    bus.done_valid   = 1'b0;
    bus.done_id      = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_kvalid", bus.kernel_valid, 0);
    check("rst_kout", bus.kernel_out, 0);
    check("rst_fifo", fifo_count, 0);
    check("rst_ids", ids_free, 16);
    check("rst_err", err_bad_release, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_stat_disp", stat_dispatched, 0);
    rst = 1'b1;

    // Single request, minimum latency
    bus.req_valid      = 4'b0001;
    bus.req_threads[0] = 4'd5;
    bus.req_pc[0]      = 32'h100;
    bus.kernel_ready   = 1'b1;
    launch_en          = 1'b1;
    #1 check("t1_ready", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    check("t1_kvalid_e1", bus.kernel_valid, 0);
    check("t1_fifo_e1", fifo_count, 1);
    @(negedge clk);
    k1 = '{warp_id: '0, start_pc: 32'h100, thread_count: 4'd5};
    check("t1_kvalid_e2", bus.kernel_valid, 1);
    check("t1_kout", bus.kernel_out, k1);
    check("t1_fifo_e2", fifo_count, 0);
    check("t1_ids", ids_free, 15);
    @(negedge clk);
    check("t1_kvalid_done", bus.kernel_valid, 0);
    bus.done_valid = 1'b1;
    bus.done_id    = 4'd0;
    @(negedge clk);
    bus.done_valid = 1'b0;
    check("t1_ids_back", ids_free, 16);
    check("t1_err", err_bad_release, 0);

    // Round-robin fill with dispatch disabled
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_pc[i]      = 32'h1000 + 32'(i) * 32'h10;
      bus.req_threads[i] = THREAD_W'(i + 1);
    end
    launch_en        = 1'b0;
    bus.kernel_ready = 1'b0;
    bus.req_valid    = 4'b1111;
    for (int k = 0; k < 32; k++) begin
      #1 check($sformatf("t2_grant%0d", k), bus.req_ready, 4'b0001 << (k % 4));
      @(negedge clk);
    end
    #1;
    check("t2_full_ready", bus.req_ready, 0);
    check("t2_fifo", fifo_count, 32);
    check("t2_no_launch", bus.kernel_valid, 0);
    @(negedge clk);
    check("t2_fifo_hold", fifo_count, 32);

    // Dispatch until IDs run out
    bus.req_valid    = '0;
    launch_en        = 1'b1;
    bus.kernel_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      check($sformatf("t3_valid%0d", j), bus.kernel_valid, 1);
      check($sformatf("t3_kout%0d", j), bus.kernel_out, exp_k(j, j));
    end
    check("t3_ids_zero", ids_free, 0);
    @(negedge clk);
    check("t3_stall_valid", bus.kernel_valid, 0);
    check("t3_stall_fifo", fifo_count, 16);
    @(negedge clk);
    check("t3_stall_valid2", bus.kernel_valid, 0);
    bus.done_valid = 1'b1;
    bus.done_id    = 4'd7;
    @(negedge clk);
    bus.done_valid = 1'b0;
    check("t3_rel_no_load", bus.kernel_valid, 0);
    check("t3_rel_ids", ids_free, 1);
    @(negedge clk);
    check("t3_id7_valid", bus.kernel_valid, 1);
    check("t3_id7_kout", bus.kernel_out, exp_k(7, 16));
    check("t3_id7_fifo", fifo_count, 15);

    // Backpressure hold, then one warp per cycle
    bus.kernel_ready = 1'b0;
    for (int h = 0; h < 5; h++) begin
      bus.done_valid = 1'b1;
      bus.done_id    = ID_W'(h);
      @(negedge clk);
      check($sformatf("t4_hold_valid%0d", h), bus.kernel_valid, 1);
      check($sformatf("t4_hold_kout%0d", h), bus.kernel_out, exp_k(7, 16));
    end
    bus.done_valid = 1'b0;
    check("t4_ids5", ids_free, 5);
    bus.kernel_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("t4_b2b_valid%0d", j), bus.kernel_valid, 1);
      check($sformatf("t4_b2b_kout%0d", j), bus.kernel_out, exp_k(j, 17 + j));
    end
    bus.kernel_ready = 1'b0;
    check("t4_fifo10", fifo_count, 10);
    check("t4_ids0", ids_free, 0);
`ifdef WARP_DISPATCH_STATS_EN
    check("t4_stat_disp", stat_dispatched, 21);
    check("t4_stat_stall_nz", (stat_id_stall != 0), 1);
`else
    check("t4_stat_disp_off", stat_dispatched, 0);
    check("t4_stat_stall_off", stat_id_stall, 0);
`endif

    // Zero-thread request advances RR without enqueuing
    bus.req_threads[1] = 4'd0;
    bus.req_valid      = 4'b0010;
    #1 check("t5_zero_ready", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    check("t5_zero_fifo", fifo_count, 10);
    check("t5_zero_hold", bus.kernel_valid, 1);

    // Mid-operation asynchronous reset
    rst = 1'b0;
    #1;
    check("t6_kvalid", bus.kernel_valid, 0);
    check("t6_kout", bus.kernel_out, 0);
    check("t6_fifo", fifo_count, 0);
    check("t6_ids", ids_free, 16);
    @(negedge clk);
    rst           = 1'b1;
    launch_en     = 1'b0;
    bus.req_valid = 4'b1111;
    #1 check("t6_rr_ch0", bus.req_ready, 4'b0001);
    bus.req_valid = '0;

    // Bad release of an unallocated ID
    bus.done_valid = 1'b1;
    bus.done_id    = 4'd3;
    @(negedge clk);
    bus.done_valid = 1'b0;
    check("t5_bad_err", err_bad_release, 1);
    check("t5_bad_ids", ids_free, 16);
    @(negedge clk);
    check("t5_bad_sticky", err_bad_release, 1);

    // Zero-thread requests on two channels
    bus.req_threads[0] = 4'd0;
    bus.req_valid      = 4'b0011;
    #1 check("t5_z_ch0", bus.req_ready, 4'b0001);
    @(negedge clk);
    #1 check("t5_z_ch1", bus.req_ready, 4'b0010);
    check("t5_z_fifo", fifo_count, 0);
    bus.req_valid = '0;
    @(negedge clk);
    check("t5_z_fifo2", fifo_count, 0);
    check("t5_z_valid", bus.kernel_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
